// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: burst-locking round-robin sharing of one complex multiplier between two requesters.
// Define MULT_ARB_STAT_EN to add saturating beat/conflict statistics outputs.
module mult_share_arbiter #(
    parameter int WIDTH     = 16,
    parameter int MAX_BURST = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             rq0_valid,
    input  logic             rq0_last,
    output logic             rq0_ready,
    input  logic [WIDTH-1:0] rq0_ar,
    input  logic [WIDTH-1:0] rq0_ai,
    input  logic [WIDTH-1:0] rq0_br,
    input  logic [WIDTH-1:0] rq0_bi,
    input  logic             rq1_valid,
    input  logic             rq1_last,
    output logic             rq1_ready,
    input  logic [WIDTH-1:0] rq1_ar,
    input  logic [WIDTH-1:0] rq1_ai,
    input  logic [WIDTH-1:0] rq1_br,
    input  logic [WIDTH-1:0] rq1_bi,
    output logic [WIDTH-1:0] mul_ar,
    output logic [WIDTH-1:0] mul_ai,
    output logic [WIDTH-1:0] mul_br,
    output logic [WIDTH-1:0] mul_bi,
    input  logic [WIDTH-1:0] mul_mr,
    input  logic [WIDTH-1:0] mul_mi,
    output logic             out_valid,
    output logic             out_id,
    output logic [WIDTH-1:0] out_mr,
    output logic [WIDTH-1:0] out_mi
`ifdef MULT_ARB_STAT_EN
    ,
    output logic [15:0]      stat_beats0,
    output logic [15:0]      stat_beats1,
    output logic [15:0]      stat_conflict
`endif
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] OWN0 = 2'd1;
    localparam logic [1:0] OWN1 = 2'd2;

    logic [1:0] state, state_nxt;
    logic       rr_ptr, rr_nxt;
    logic [7:0] beat_cnt, cnt_nxt;
    logic       own, sel, cur_valid, cur_last, oth_valid, acc, hit, leave;
    logic       vld_p, id_p;

    assign own       = (state == OWN0) || (state == OWN1);
    assign sel       = state == OWN1;
    assign cur_valid = sel ? rq1_valid : rq0_valid;
    assign cur_last  = sel ? rq1_last : rq0_last;
    assign oth_valid = sel ? rq0_valid : rq1_valid;
    assign acc       = own && cur_valid;
    assign hit       = acc && ({1'b0, beat_cnt} + 9'd1 == 9'(MAX_BURST));
    assign leave     = own && (!cur_valid || (acc && cur_last) || hit);
    // ready depends only on the registered state, never on the competing requester
    assign rq0_ready = state == OWN0;
    assign rq1_ready = state == OWN1;

    always_comb begin
        state_nxt = own ? state : IDLE;
        rr_nxt    = rr_ptr;
        cnt_nxt   = acc ? beat_cnt + 8'd1 : beat_cnt;
        if (!own) begin
            state_nxt = (rq0_valid && (!rq1_valid || !rr_ptr)) ? OWN0 : rq1_valid ? OWN1 : IDLE;
            cnt_nxt   = 8'd0;
        end else if (leave) begin
            rr_nxt    = ~sel;
            cnt_nxt   = 8'd0;
            state_nxt = oth_valid ? (sel ? OWN0 : OWN1) : (cur_valid && !cur_last) ? state : IDLE;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            rr_ptr    <= 1'b0;
            beat_cnt  <= 8'd0;
            mul_ar    <= '0;
            mul_ai    <= '0;
            mul_br    <= '0;
            mul_bi    <= '0;
            vld_p     <= 1'b0;
            id_p      <= 1'b0;
            out_valid <= 1'b0;
            out_id    <= 1'b0;
            out_mr    <= '0;
            out_mi    <= '0;
        end else begin
            state     <= state_nxt;
            rr_ptr    <= rr_nxt;
            beat_cnt  <= cnt_nxt;
            vld_p     <= acc;
            out_valid <= vld_p;
            if (acc) begin
                mul_ar <= sel ? rq1_ar : rq0_ar;
                mul_ai <= sel ? rq1_ai : rq0_ai;
                mul_br <= sel ? rq1_br : rq0_br;
                mul_bi <= sel ? rq1_bi : rq0_bi;
                id_p   <= sel;
            end
            if (vld_p) begin
                out_mr <= mul_mr;
                out_mi <= mul_mi;
                out_id <= id_p;
            end
        end
    end

`ifdef MULT_ARB_STAT_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stat_beats0   <= 16'd0;
            stat_beats1   <= 16'd0;
            stat_conflict <= 16'd0;
        end else begin
            if (acc && !sel && stat_beats0 != 16'hFFFF) stat_beats0 <= stat_beats0 + 16'd1;
            if (acc && sel && stat_beats1 != 16'hFFFF) stat_beats1 <= stat_beats1 + 16'd1;
            // with a single grant, both valid always means one of them is stalled
            if (rq0_valid && rq1_valid && stat_conflict != 16'hFFFF) stat_conflict <= stat_conflict + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb_mult_share_arbiter: scoreboard bench for mult_share_arbiter with a Q1.15 complex multiplier model.
// Build with MULT_ARB_STAT_EN defined to also exercise the statistics counters.
module tb_mult_share_arbiter;
    localparam int W = 16;
    typedef struct packed {
        logic         id;
        logic [W-1:0] mr;
        logic [W-1:0] mi;
    } res_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic rq0_valid = 1'b0, rq0_last = 1'b0, rq0_ready;
    logic rq1_valid = 1'b0, rq1_last = 1'b0, rq1_ready;
    logic [W-1:0] rq0_ar = '0, rq0_ai = '0, rq0_br = '0, rq0_bi = '0;
    logic [W-1:0] rq1_ar = '0, rq1_ai = '0, rq1_br = '0, rq1_bi = '0;
    logic [W-1:0] mul_ar, mul_ai, mul_br, mul_bi, mul_mr, mul_mi;
    logic out_valid, out_id;
    logic [W-1:0] out_mr, out_mi;
`ifdef MULT_ARB_STAT_EN
    logic [15:0] stat_beats0, stat_beats1, stat_conflict;
`endif

    res_t q[$];
    int tests = 0, fails = 0, acc_cnt = 0, out_cnt = 0;

    always #5 clock = ~clock;

    mult_share_arbiter #(.WIDTH(W), .MAX_BURST(4)) dut (
        .clock(clock), .reset(reset),
        .rq0_valid(rq0_valid), .rq0_last(rq0_last), .rq0_ready(rq0_ready),
        .rq0_ar(rq0_ar), .rq0_ai(rq0_ai), .rq0_br(rq0_br), .rq0_bi(rq0_bi),
        .rq1_valid(rq1_valid), .rq1_last(rq1_last), .rq1_ready(rq1_ready),
        .rq1_ar(rq1_ar), .rq1_ai(rq1_ai), .rq1_br(rq1_br), .rq1_bi(rq1_bi),
        .mul_ar(mul_ar), .mul_ai(mul_ai), .mul_br(mul_br), .mul_bi(mul_bi),
        .mul_mr(mul_mr), .mul_mi(mul_mi),
        .out_valid(out_valid), .out_id(out_id), .out_mr(out_mr), .out_mi(out_mi)
`ifdef MULT_ARB_STAT_EN
        , .stat_beats0(stat_beats0), .stat_beats1(stat_beats1), .stat_conflict(stat_conflict)
`endif
    );

    function automatic logic [2*W-1:0] cmul(input logic [W-1:0] ar, ai, br, bi);
        logic signed [2*W-1:0] pr, pi;
        pr = $signed(ar) * $signed(br) - $signed(ai) * $signed(bi);
        pi = $signed(ar) * $signed(bi) + $signed(ai) * $signed(br);
        return {pr[2*W-2:W-1], pi[2*W-2:W-1]};
    endfunction

    // external shared multiplier
    always_comb {mul_mr, mul_mi} = cmul(mul_ar, mul_ai, mul_br, mul_bi);

    always @(negedge clock) begin : monitor
        res_t e;
        if (!reset) q.delete();
        else begin
            if (out_valid) begin
                out_cnt++;
                tests++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_out: out_valid=1 id=%0d, required no result pending", out_id);
                end else begin
                    e = q.pop_front();
                    if ({out_id, out_mr, out_mi} !== e) begin
                        fails++;
                        $display("FAIL scoreboard: got id=%0d mr=%h mi=%h, required id=%0d mr=%h mi=%h",
                                 out_id, out_mr, out_mi, e.id, e.mr, e.mi);
                    end
                end
            end
            if (rq0_valid && rq0_ready) begin
                acc_cnt++;
                q.push_back({1'b0, cmul(rq0_ar, rq0_ai, rq0_br, rq0_bi)});
            end
            if (rq1_valid && rq1_ready) begin
                acc_cnt++;
                q.push_back({1'b1, cmul(rq1_ar, rq1_ai, rq1_br, rq1_bi)});
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic rnd0();
        rq0_ar = W'($urandom); rq0_ai = W'($urandom); rq0_br = W'($urandom); rq0_bi = W'($urandom);
    endtask

    task automatic rnd1();
        rq1_ar = W'($urandom); rq1_ai = W'($urandom); rq1_br = W'($urandom); rq1_bi = W'($urandom);
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        step();
        reset = 1'b1;
        step();
    endtask

    task automatic test_reset();
        int base, o0, n;
        repeat (2) step();
        @(negedge clock);
        tests++;
        if ({rq0_ready, rq1_ready, out_valid, out_id} !== 4'b0) begin
            fails++;
            $display("FAIL reset_ctrl: got %b, required 0000", {rq0_ready, rq1_ready, out_valid, out_id});
        end
        tests++;
        if ({out_mr, out_mi, mul_ar, mul_ai, mul_br, mul_bi} !== '0) begin
            fails++;
            $display("FAIL reset_data: got out=%h/%h mul_ar=%h, required 0", out_mr, out_mi, mul_ar);
        end
        step();
        reset = 1'b1;
        rnd0();
        rq0_valid = 1'b1;
        base = acc_cnt;
        n = 0;
        while (acc_cnt - base < 3 && n < 50) begin
            step();
            n++;
        end
        tests++;
        if (acc_cnt - base != 3) begin
            fails++;
            $display("FAIL reset_burst_accept: got %0d beats, required 3", acc_cnt - base);
        end
        reset = 1'b0;
        rq0_valid = 1'b0;
        @(negedge clock);
        tests++;
        if ({rq0_ready, rq1_ready, out_valid, out_id, out_mr, out_mi, mul_ar} !== '0) begin
            fails++;
            $display("FAIL reset_mid_burst: got ready=%b vld=%b out=%h/%h mul_ar=%h, required all 0",
                     rq0_ready, out_valid, out_mr, out_mi, mul_ar);
        end
        step();
        reset = 1'b1;
        o0 = out_cnt;
        repeat (5) step();
        tests++;
        if (out_cnt != o0) begin
            fails++;
            $display("FAIL reset_discard: got %0d results after reset, required 0", out_cnt - o0);
        end
    endtask

    task automatic test_single();
        int n = 0;
        rq0_ar = 16'h4000; rq0_ai = 16'h0; rq0_br = 16'h0; rq0_bi = 16'h4000;
        rq0_last = 1'b1;
        rq0_valid = 1'b1;
        @(negedge clock);
        while (!rq0_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        tests++;
        if (!rq0_ready) begin
            fails++;
            $display("FAIL single_grant: got no ready within 20 cycles, required ready");
        end
        step();
        rq0_valid = 1'b0;
        rq0_last = 1'b0;
        @(negedge clock);
        tests++;
        if ({out_valid, mul_ar, mul_bi} !== {1'b0, 16'h4000, 16'h4000}) begin
            fails++;
            $display("FAIL single_stage1: got vld=%b mul_ar=%h mul_bi=%h, required 0 4000 4000",
                     out_valid, mul_ar, mul_bi);
        end
        @(negedge clock);
        tests++;
        if ({out_valid, out_id, out_mr, out_mi} !== {1'b1, 1'b0, 16'h0000, 16'h2000}) begin
            fails++;
            $display("FAIL single_result: got vld=%b id=%0d mr=%h mi=%h, required 1 0 0000 2000",
                     out_valid, out_id, out_mr, out_mi);
        end
        @(negedge clock);
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL single_one_shot: got out_valid=%b, required 0", out_valid);
        end
    endtask

    task automatic test_contention();
        int n = 0;
        logic [1:0] g;
        pulse_reset();
        rnd0();
        rnd1();
        rq0_last = 1'b0;
        rq1_last = 1'b0;
        rq0_valid = 1'b1;
        rq1_valid = 1'b1;
        @(negedge clock);
        while (!rq0_ready && !rq1_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        for (int i = 0; i < 16; i++) begin
            g = rq0_ready ? 2'd0 : rq1_ready ? 2'd1 : 2'd2;
            tests++;
            if (g !== 2'((i / 4) % 2)) begin
                fails++;
                $display("FAIL contention_grant[%0d]: got %0d, required %0d", i, g, (i / 4) % 2);
            end
            step();
            rnd0();
            rnd1();
            @(negedge clock);
        end
`ifdef MULT_ARB_STAT_EN
        tests++;
        if (stat_conflict == 16'd0) begin
            fails++;
            $display("FAIL stat_conflict: got 0, required nonzero");
        end
`endif
        step();
        rq0_valid = 1'b0;
        rq1_valid = 1'b0;
        repeat (4) step();
    endtask

    task automatic test_handoff();
        int n = 0, base;
        rnd1();
        rq1_last = 1'b0;
        rq1_valid = 1'b1;
        base = acc_cnt;
        @(negedge clock);
        while (!rq1_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        step();
        rnd0();
        rnd1();
        rq0_valid = 1'b1;
        step();
        rnd1();
        rq1_last = 1'b1;
        step();
        rq1_valid = 1'b0;
        rq1_last = 1'b0;
        tests++;
        if (acc_cnt - base != 3) begin
            fails++;
            $display("FAIL handoff_rq1_beats: got %0d, required 3", acc_cnt - base);
        end
        @(negedge clock);
        tests++;
        if ({rq0_ready, rq1_ready} !== 2'b10) begin
            fails++;
            $display("FAIL handoff_grant: got rq0_ready=%b rq1_ready=%b, required 1 0", rq0_ready, rq1_ready);
        end
        step();
        rnd0();
        step();
        rq0_valid = 1'b0;
        repeat (4) step();
    endtask

    task automatic test_gap();
        int base_a = acc_cnt, base_o = out_cnt, n;
        for (int k = 0; k < 6; k++) begin
            rnd0();
            rq0_valid = 1'b1;
            n = 0;
            @(negedge clock);
            while (!rq0_ready && n < 20) begin
                @(negedge clock);
                n++;
            end
            step();
            if (k == 2) begin
                rq0_valid = 1'b0;
                step();
            end
        end
        rq0_valid = 1'b0;
        repeat (5) step();
        tests++;
        if (acc_cnt - base_a != 6) begin
            fails++;
            $display("FAIL gap_accepted: got %0d, required 6", acc_cnt - base_a);
        end
        tests++;
        if (out_cnt - base_o != 6) begin
            fails++;
            $display("FAIL gap_outputs: got %0d, required 6", out_cnt - base_o);
        end
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL gap_pending: got %0d results pending, required 0", q.size());
        end
    endtask

`ifdef MULT_ARB_STAT_EN
    task automatic test_stat();
        pulse_reset();
        tests++;
        if ({stat_beats0, stat_beats1, stat_conflict} !== '0) begin
            fails++;
            $display("FAIL stat_reset: got %h %h %h, required 0", stat_beats0, stat_beats1, stat_conflict);
        end
        rnd0();
        rq0_last = 1'b0;
        rq0_valid = 1'b1;
        repeat (70000) step();
        rq0_valid = 1'b0;
        repeat (4) step();
        tests++;
        if (stat_beats0 !== 16'hFFFF || stat_beats1 !== 16'h0) begin
            fails++;
            $display("FAIL stat_saturate: got beats0=%h beats1=%h, required FFFF 0000", stat_beats0, stat_beats1);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_handoff();
        test_gap();
`ifdef MULT_ARB_STAT_EN
        test_stat();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
